// File: rtl/fifo_pkg.sv
// Shared types and helpers for sync_fifo_prog: count-width helper and the
// bundled status-flag struct (also used by bench monitors).
package fifo_pkg;

    // Occupancy must reach DEPTH itself, hence one bit more than the pointers.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic wfull;
        logic rempty;
        logic half_full;
        logic half_rempty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bus for sync_fifo_prog: push/pop handshake, thresholds,
// occupancy and status flags. master = FIFO user, slave = the FIFO.
interface sync_fifo_prog_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    import fifo_pkg::*;
    localparam int CW = cnt_width(DEPTH);

    logic                  write_enable;
    logic [DATA_WIDTH-1:0] data_write;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] data_read;
    logic [CW-1:0]         af_thresh;
    logic [CW-1:0]         ae_thresh;
    logic [CW-1:0]         count;
    logic                  wfull;
    logic                  rempty;
    logic                  half_full;
    logic                  half_rempty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write_enable, data_write, read_enable, af_thresh, ae_thresh,
        input  data_read, count, wfull, rempty, half_full, half_rempty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  write_enable, data_write, read_enable, af_thresh, ae_thresh,
        output data_read, count, wfull, rempty, half_full, half_rempty,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one
// asynchronous read port. Contents are intentionally never reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_WIDTH-1:0]      i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [DATA_WIDTH-1:0]      o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost flags and sticky
// overflow/underflow. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input logic             clk,
    input logic             rst_n,
    sync_fifo_prog_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CW         = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] HALF_CNT = CW'(DEPTH / 2);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [DATA_WIDTH-1:0] w_head;
    fifo_flags_t           w_flags;

    // A pop frees the slot in the same edge, so a full FIFO still takes a push.
    assign w_rd_acc = bus.read_enable & (r_count != '0);
    assign w_wr_acc = bus.write_enable & ((r_count != FULL_CNT) | w_rd_acc);

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .i_clk  (clk),
        .i_we   (w_wr_acc),
        .i_waddr(r_wr_ptr),
        .i_wdata(bus.data_write),
        .i_raddr(r_rd_ptr),
        .o_rdata(w_head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (bus.write_enable & ~w_wr_acc)          r_overflow  <= 1'b1;
            if (bus.read_enable & (r_count == '0))     r_underflow <= 1'b1;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.data_read = (r_count != '0) ? w_head : '0;
`else
    logic [DATA_WIDTH-1:0] r_data_read;

    always_ff @(posedge clk) begin
        if (!rst_n)        r_data_read <= '0;
        else if (w_rd_acc) r_data_read <= w_head;
    end

    assign bus.data_read = r_data_read;
`endif

    always_comb begin
        w_flags              = '0;
        w_flags.wfull        = (r_count == FULL_CNT);
        w_flags.rempty       = (r_count == '0);
        w_flags.half_full    = (r_count >= HALF_CNT);
        w_flags.half_rempty  = (r_count <  HALF_CNT);
        w_flags.almost_full  = (r_count >= bus.af_thresh);
        w_flags.almost_empty = (r_count <= bus.ae_thresh);
    end

    assign bus.count        = r_count;
    assign bus.wfull        = w_flags.wfull;
    assign bus.rempty       = w_flags.rempty;
    assign bus.half_full    = w_flags.half_full;
    assign bus.half_rempty  = w_flags.half_rempty;
    assign bus.almost_full  = w_flags.almost_full;
    assign bus.almost_empty = w_flags.almost_empty;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: queue-based reference model checked every cycle,
// plus directed literal checks. Honours SYNC_FIFO_FWFT_EN like the design.
module tb_sync_fifo_prog;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    sync_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dr;
    logic          m_ovf, m_unf, m_valid = 1'b0;

    always @(posedge clk) begin
        bit rd, wr;
        if (!rst_n) begin
            q.delete();
            m_dr = '0; m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b1;
        end else begin
            rd = bus.read_enable && (q.size() > 0);
            wr = bus.write_enable && ((q.size() < DEPTH) || rd);
            if (bus.write_enable && !wr)                 m_ovf = 1'b1;
            if (bus.read_enable && (q.size() == 0))      m_unf = 1'b1;
            if (rd) m_dr = q.pop_front();
            if (wr) q.push_back(bus.data_write);
        end
    end

    always @(negedge clk) begin
        int n;
        logic [DW-1:0] e_dr;
        logic [31:0] act, exp;
        if (m_valid) begin
            n = q.size();
`ifdef SYNC_FIFO_FWFT_EN
            e_dr = (n != 0) ? q[0] : '0;
`else
            e_dr = m_dr;
`endif
            exp = {9'd0, 5'(n), n == DEPTH, n == 0, n >= DEPTH/2, n < DEPTH/2,
                   n >= int'(bus.af_thresh), n <= int'(bus.ae_thresh), m_ovf, m_unf, e_dr};
            act = {9'd0, bus.count, bus.wfull, bus.rempty, bus.half_full, bus.half_rempty,
                   bus.almost_full, bus.almost_empty, bus.overflow, bus.underflow, bus.data_read};
            chk("cycle_model", act, exp);
        end
    end

    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
        bus.write_enable = we;
        bus.data_write   = wd;
        bus.read_enable  = re;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    // Pop one word and check it is the expected one at the mode's read latency.
    task automatic pop_check(input string name, input logic we, input logic [DW-1:0] wd,
                             input logic [DW-1:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
        chk(name, 32'(bus.data_read), 32'(exp));
        step(we, wd, 1'b1);
`else
        step(we, wd, 1'b1);
        chk(name, 32'(bus.data_read), 32'(exp));
`endif
    endtask

    initial begin
        logic [DW-1:0] exp_w;
        rst_n            = 1'b0;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        bus.data_write   = '0;
        bus.af_thresh    = 5'd14;
        bus.ae_thresh    = 5'd2;

        // 1: reset and idle
        do_reset();
        step(1'b0, '0, 1'b0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_rempty", 32'(bus.rempty), 32'd1);
        chk("rst_half_rempty", 32'(bus.half_rempty), 32'd1);
        chk("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
        chk("rst_wfull", 32'(bus.wfull), 32'd0);
        chk("rst_data_read", 32'(bus.data_read), 32'd0);
        chk("rst_errs", 32'({bus.overflow, bus.underflow}), 32'd0);

        // 2: fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0);
            if (i == 6)  chk("half_full_7",  32'(bus.half_full), 32'd0);
            if (i == 7)  chk("half_full_8",  32'(bus.half_full), 32'd1);
            if (i == 12) chk("afull_13", 32'(bus.almost_full), 32'd0);
            if (i == 13) chk("afull_14", 32'(bus.almost_full), 32'd1);
            if (i == 14) chk("wfull_15", 32'(bus.wfull), 32'd0);
        end
        chk("wfull_16", 32'(bus.wfull), 32'd1);
        chk("count_16", 32'(bus.count), 32'd16);
        step(1'b1, 8'hEE, 1'b0);
        chk("overflow_set", 32'(bus.overflow), 32'd1);
        chk("count_hold_16", 32'(bus.count), 32'd16);
        bus.ae_thresh = 5'd16;
        #1 chk("ae_thresh_16", 32'(bus.almost_empty), 32'd1);
        bus.ae_thresh = 5'd2;

        // 3: drain in order, then underflow
        for (int i = 0; i < DEPTH; i++) pop_check("drain_order", 1'b0, '0, DW'(i));
        step(1'b0, '0, 1'b1);
        chk("underflow_set", 32'(bus.underflow), 32'd1);
        chk("drain_rempty", 32'(bus.rempty), 32'd1);
        bus.af_thresh = 5'd0;
        #1 chk("af_thresh_0", 32'(bus.almost_full), 32'd1);
        bus.af_thresh = 5'd14;

        // 4: simultaneous push/pop at full
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0);
        for (int k = 0; k < 4; k++) pop_check("full_rw_head", 1'b1, DW'(8'hA0 + k), DW'(k));
        chk("full_rw_count", 32'(bus.count), 32'd16);
        chk("full_rw_no_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            exp_w = (i < 12) ? DW'(i + 4) : DW'(8'hA0 + i - 12);
            pop_check("full_rw_drain", 1'b0, '0, exp_w);
        end
        chk("full_rw_empty", 32'(bus.rempty), 32'd1);

        // 5: push and pop together while empty
        step(1'b1, 8'h55, 1'b1);
        chk("empty_rw_count", 32'(bus.count), 32'd1);
        chk("empty_rw_unf", 32'(bus.underflow), 32'd1);
        pop_check("empty_rw_data", 1'b0, '0, 8'h55);

        // 6: pointer wrap at count 8, then mid-stream reset
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h10 + i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            exp_w = (i < 8) ? DW'(8'h10 + i) : DW'(8'h20 + i - 8);
            pop_check("wrap_order", 1'b1, DW'(8'h20 + i), exp_w);
        end
        chk("wrap_count", 32'(bus.count), 32'd8);
        rst_n = 1'b0;
        step(1'b1, 8'h99, 1'b1);
        rst_n = 1'b1;
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_errs", 32'({bus.overflow, bus.underflow}), 32'd0);
        chk("midrst_data", 32'(bus.data_read), 32'd0);
        step(1'b1, 8'h77, 1'b0);
        pop_check("midrst_new", 1'b0, '0, 8'h77);
        step(1'b0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
